// File: rtl/log_pkg.sv
// Shared definitions for the log readout path and the host-side decoder.
// Byte order on the stream is MSB first: word[31:24] leaves first, word[7:0]
// last, i.e. I_b, Q_b, I_a, Q_a for a {bram_b, bram_a} word.
package log_pkg;

  typedef enum logic [2:0] {
    LR_IDLE,
    LR_ARM,
    LR_ADDR,
    LR_LOAD,
    LR_SEND,
    LR_DONE
  } lr_state_e;

  localparam int LR_BYTE_BITS       = 8;
  localparam int LR_DATA_WIDTH_DFLT = 16;
  localparam int BYTES_PER_WORD     = 2 * LR_DATA_WIDTH_DFLT / LR_BYTE_BITS;

  // Number of stream bytes carried by one {bank_b, bank_a} log word.
  function automatic int bytes_per_word(input int data_width);
    return 2 * data_width / LR_BYTE_BITS;
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Parallel-load word to MSB-first byte stream with a valid/ready handshake.
// o_byte and o_valid come straight from flops; o_last flags the handshake of
// the final byte so the controller can advance in that same cycle.
module word_serializer
  import log_pkg::*;
#(
  parameter int NBYTES = BYTES_PER_WORD
) (
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic                       i_load,
  input  logic                       i_clear,
  input  logic [NBYTES*8-1:0]        i_word,
  input  logic                       i_ready,
  output logic [7:0]                 o_byte,
  output logic                       o_valid,
  output logic                       o_last
);

  localparam int WW = NBYTES * LR_BYTE_BITS;
  localparam int CW = $clog2(NBYTES + 1);

  logic [WW-1:0] shift_q;
  logic [CW-1:0] cnt_q;
  logic          valid_q;
  logic          handshake;

  assign handshake = valid_q & i_ready;

  // Load a word, then shift one byte out per accepted handshake.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (i_clear) begin
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (i_load) begin
      shift_q <= i_word;
      cnt_q   <= CW'(NBYTES);
      valid_q <= 1'b1;
    end else if (handshake) begin
      shift_q <= shift_q << LR_BYTE_BITS;
      cnt_q   <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign o_byte  = shift_q[WW-1 -: 8];
  assign o_valid = valid_q;
  assign o_last  = handshake && (cnt_q == CW'(1));

endmodule

// File: rtl/log_readout.sv
// Readout controller: after the logger is full, switches it to read mode,
// sweeps every log address once and streams each word out MSB first.
module log_readout
  import log_pkg::*;
#(
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int BRAM_DATA_WIDTH = 16,
  parameter int RD_LAT          = 1
) (
  input  logic                         clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  input  logic                         i_abort,
  input  logic                         i_mem_full,
  input  logic [2*BRAM_DATA_WIDTH-1:0] i_data_log,
  output logic                         o_read_log,
  output logic [BRAM_ADDR_WIDTH-1:0]   o_addr_log,
  output logic [7:0]                   o_byte,
  output logic                         o_byte_valid,
  input  logic                         i_byte_ready,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_start_err
);

  localparam int NBYTES = bytes_per_word(BRAM_DATA_WIDTH);
  localparam int LAT_W  = 3;

  lr_state_e                  state_q;
  logic [BRAM_ADDR_WIDTH-1:0] addr_q;
  logic [LAT_W-1:0]           lat_q;
  logic                       read_log_q;
  logic                       busy_q;
  logic                       done_q;
  logic                       start_err_q;

  logic ser_load;
  logic ser_clear;
  logic ser_last;

  // Abort only matters once a sweep is underway; in IDLE it is a no-op.
  assign ser_load  = (state_q == LR_LOAD) && !i_abort;
  assign ser_clear = i_abort && (state_q != LR_IDLE);

  word_serializer #(
    .NBYTES (NBYTES)
  ) u_ser (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_load  (ser_load),
    .i_clear (ser_clear),
    .i_word  (i_data_log),
    .i_ready (i_byte_ready),
    .o_byte  (o_byte),
    .o_valid (o_byte_valid),
    .o_last  (ser_last)
  );

  // Sweep FSM with address and read-latency counters; every output is a flop.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= LR_IDLE;
      addr_q      <= '0;
      lat_q       <= '0;
      read_log_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      start_err_q <= 1'b0;
    end else begin
      read_log_q  <= 1'b0;
      done_q      <= 1'b0;
      start_err_q <= 1'b0;
      if (i_abort && (state_q != LR_IDLE)) begin
        state_q <= LR_IDLE;
        addr_q  <= '0;
        lat_q   <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          LR_IDLE: begin
            if (i_start) begin
              if (i_mem_full) begin
                state_q    <= LR_ARM;
                read_log_q <= 1'b1;
                busy_q     <= 1'b1;
                addr_q     <= '0;
              end else begin
                start_err_q <= 1'b1;
              end
            end
          end
          LR_ARM: begin
            state_q <= LR_ADDR;
            lat_q   <= '0;
          end
          LR_ADDR: begin
            // The address has been stable since ARM or the last handshake;
            // wait RD_LAT cycles here before sampling the logger.
            if (lat_q == LAT_W'(RD_LAT - 1)) begin
              state_q <= LR_LOAD;
            end else begin
              lat_q <= lat_q + LAT_W'(1);
            end
          end
          LR_LOAD: begin
            state_q <= LR_SEND;
          end
          LR_SEND: begin
            if (ser_last) begin
              if (addr_q == '1) begin
                state_q <= LR_DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                addr_q  <= '0;
              end else begin
                state_q <= LR_ADDR;
                addr_q  <= addr_q + BRAM_ADDR_WIDTH'(1);
                lat_q   <= '0;
              end
            end
          end
          LR_DONE: begin
            state_q <= LR_IDLE;
          end
          default: begin
            state_q <= LR_IDLE;
          end
        endcase
      end
    end
  end

  assign o_read_log  = read_log_q;
  assign o_addr_log  = addr_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_start_err = start_err_q;

endmodule
